// File: rtl/can_stuff_sequencer.sv
// CAN TX bit-stuffing sequencer: forwards frame bits, inserts a complemented bit after STUFF_LEN identical bits.
// Latency: 1 clk from accepted bit (or stuff/idle bit_tick) to tx_bit_o.
// Backpressure: in_ready_o only on bit_tick in IDLE/SEND without abort; held low while a stuff bit goes out.
module can_stuff_sequencer #(
    parameter int STUFF_LEN = 5,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_tick_i,
    input  logic             abort_i,
    input  logic             stuff_en_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             tx_bit_o,
    output logic             stuff_pulse_o,
    output logic [CNT_W-1:0] stuff_count_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             underrun_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_STUFF = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0]       RUN_LEN = 4'(STUFF_LEN);
    localparam logic [3:0]       RUN_ONE = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             tx_bit_q, tx_bit_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic             run_val_q, run_val_d;
    logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
    logic             last_q, last_d;
    logic             stuff_pulse_q, stuff_pulse_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic [3:0]       run_inc;
    logic [3:0]       run_new;

    assign in_ready_o    = bit_tick_i & ((state_q == S_IDLE) | (state_q == S_SEND)) & ~abort_i;
    assign accept        = in_valid_i & in_ready_o;
    assign tx_bit_o      = tx_bit_q;
    assign stuff_pulse_o = stuff_pulse_q;
    assign stuff_count_o = stuff_cnt_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign underrun_o    = underrun_q;

    // Run length after an accepted SEND bit; saturates at STUFF_LEN so it never wraps.
    always_comb begin
        run_inc = (run_cnt_q >= RUN_LEN) ? RUN_LEN : (run_cnt_q + RUN_ONE);
        run_new = (in_bit_i == run_val_q) ? run_inc : RUN_ONE;
    end

    // Next-state logic: abort dominates, otherwise everything but DONE->IDLE waits for bit_tick.
    always_comb begin
        state_d       = state_q;
        tx_bit_d      = tx_bit_q;
        run_cnt_d     = run_cnt_q;
        run_val_d     = run_val_q;
        stuff_cnt_d   = stuff_cnt_q;
        last_d        = last_q;
        stuff_pulse_d = 1'b0;
        underrun_d    = 1'b0;
        if (abort_i) begin
            state_d   = S_IDLE;
            tx_bit_d  = 1'b1;
            run_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // First bit of a frame; a single bit can never complete a run (STUFF_LEN >= 2).
                        tx_bit_d    = in_bit_i;
                        run_cnt_d   = RUN_ONE;
                        run_val_d   = in_bit_i;
                        stuff_cnt_d = '0;
                        last_d      = in_last_i;
                        state_d     = in_last_i ? S_DONE : S_SEND;
                    end else if (bit_tick_i) begin
                        tx_bit_d = 1'b1;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        tx_bit_d  = in_bit_i;
                        run_cnt_d = run_new;
                        run_val_d = in_bit_i;
                        if (stuff_en_i && (run_new == RUN_LEN)) begin
                            state_d = S_STUFF;
                            last_d  = in_last_i;
                        end else if (in_last_i) begin
                            state_d = S_DONE;
                        end
                    end else if (bit_tick_i) begin
                        // Upstream missed its bit time mid-frame: drop the frame, keep the stuff count.
                        underrun_d = 1'b1;
                        tx_bit_d   = 1'b1;
                        run_cnt_d  = 4'd0;
                        state_d    = S_IDLE;
                    end
                end
                S_STUFF: begin
                    if (bit_tick_i) begin
                        // The stuff bit itself opens a new run of the opposite polarity.
                        tx_bit_d      = ~run_val_q;
                        stuff_pulse_d = 1'b1;
                        if (stuff_cnt_q != '1) begin
                            stuff_cnt_d = stuff_cnt_q + CNT_ONE;
                        end
                        run_cnt_d = RUN_ONE;
                        run_val_d = ~run_val_q;
                        state_d   = last_q ? S_DONE : S_SEND;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to the recessive idle condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tx_bit_q      <= 1'b1;
            run_cnt_q     <= 4'd0;
            run_val_q     <= 1'b1;
            stuff_cnt_q   <= '0;
            last_q        <= 1'b0;
            stuff_pulse_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_bit_q      <= tx_bit_d;
            run_cnt_q     <= run_cnt_d;
            run_val_q     <= run_val_d;
            stuff_cnt_q   <= stuff_cnt_d;
            last_q        <= last_d;
            stuff_pulse_q <= stuff_pulse_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_can_stuff_sequencer.sv
// Directed bench for can_stuff_sequencer: each bit_tick pushes an expected record, a monitor pops and compares.
// Latency: records are checked on the falling edge after the clk edge that sampled the tick.
// Backpressure: driver holds a frame bit until the DUT accepts it; stuff ticks simply do not advance.
module tb_can_stuff_sequencer;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic tx;
        logic sp;
        logic ur;
        logic fd;
        logic rdy;
        logic busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_tick;
    logic             abort;
    logic             stuff_en;
    logic             in_valid;
    logic             in_bit;
    logic             in_last;
    logic             in_ready;
    logic             tx_bit;
    logic             stuff_pulse;
    logic [CNT_W-1:0] stuff_count;
    logic             busy;
    logic             frame_done;
    logic             underrun;

    int   checks = 0;
    int   errors = 0;
    int   test_id = 0;
    logic run_mon = 1'b0;
    logic tick_seen;
    logic rdy_seen;
    exp_t exp_q[$];
    exp_t mon_e;

    can_stuff_sequencer #(.STUFF_LEN(5), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_tick_i    (bit_tick),
        .abort_i       (abort),
        .stuff_en_i    (stuff_en),
        .in_valid_i    (in_valid),
        .in_bit_i      (in_bit),
        .in_last_i     (in_last),
        .in_ready_o    (in_ready),
        .tx_bit_o      (tx_bit),
        .stuff_pulse_o (stuff_pulse),
        .stuff_count_o (stuff_count),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL test%0d %s act=%0d req=%0d", test_id, name, act, req);
        end
    endtask

    function automatic logic sb(input string s, input int i);
        return (s[i] == "1");
    endfunction

    // Monitor: capture tick and ready as the DUT saw them at the clk edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_seen <= 1'b0;
            rdy_seen  <= 1'b0;
        end else begin
            tick_seen <= bit_tick;
            rdy_seen  <= in_ready;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard after each tick; no pulses between ticks.
    always @(negedge clk) begin
        if (run_mon && !rst) begin
            if (tick_seen) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_bit",      {31'd0, tx_bit},      {31'd0, mon_e.tx});
                    chk("stuff_pulse", {31'd0, stuff_pulse}, {31'd0, mon_e.sp});
                    chk("underrun",    {31'd0, underrun},    {31'd0, mon_e.ur});
                    chk("frame_done",  {31'd0, frame_done},  {31'd0, mon_e.fd});
                    chk("in_ready",    {31'd0, rdy_seen},    {31'd0, mon_e.rdy});
                    chk("busy",        {31'd0, busy},        {31'd0, mon_e.busy});
                end
            end else begin
                chk("stray_pulse", {31'd0, stuff_pulse | underrun | frame_done}, 32'd0);
            end
        end
    end

    // One bit_tick every 4 clk; frame bits advance only when accepted. limit caps how many bits are offered.
    task automatic run_test(input int id, input string fbits, input string fen,
                            input string etx, input string esp, input string eur,
                            input string efd, input string erdy, input string ebusy,
                            input int limit, input int abort_at, input int exp_cnt);
        int   ptr;
        int   nb;
        logic acc;
        exp_t e;
        test_id = id;
        ptr = 0;
        nb  = fbits.len();
        for (int t = 0; t < etx.len(); t++) begin
            bit_tick = 1'b1;
            abort    = (t + 1 == abort_at);
            if (ptr < nb && ptr < limit) begin
                in_valid = 1'b1;
                in_bit   = sb(fbits, ptr);
                in_last  = (ptr == nb - 1);
                stuff_en = sb(fen, ptr);
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'b0;
                in_last  = 1'b0;
                stuff_en = 1'b1;
            end
            e.tx   = sb(etx, t);
            e.sp   = sb(esp, t);
            e.ur   = sb(eur, t);
            e.fd   = sb(efd, t);
            e.rdy  = sb(erdy, t);
            e.busy = sb(ebusy, t);
            exp_q.push_back(e);
            #1;
            acc = in_valid & in_ready;
            @(negedge clk);
            bit_tick = 1'b0;
            abort    = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (acc) ptr++;
            repeat (3) @(negedge clk);
        end
        if (exp_cnt >= 0) chk("stuff_count", {24'd0, stuff_count}, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bit_tick = 1'b0;
        abort    = 1'b0;
        stuff_en = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_bit",      {31'd0, tx_bit},      32'd1);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_stuff_count", {24'd0, stuff_count}, 32'd0);
        chk("rst_pulses",      {31'd0, stuff_pulse | underrun | frame_done}, 32'd0);
        chk("rst_in_ready",    {31'd0, in_ready},    32'd0);
        rst = 1'b0;
        run_mon = 1'b1;
        repeat (2) @(negedge clk);

        // Two stuff bits; the first stuff bit counts toward the following run of ones.
        run_test(1, "000001111100", "111111111111",
                 "000001111101001", "000001000010000", "000000000000000",
                 "000000000000010", "111110111101111", "111111111111110",
                 99, 0, 2);
        // Last bit completes a run: trailing stuff bit precedes frame_done.
        run_test(2, "1100000", "1111111",
                 "110000011", "000000010", "000000000",
                 "000000010", "111111101", "111111110",
                 99, 0, 1);
        // Stuffing disabled over a long run of ones: no insertion, count cleared by new frame.
        run_test(3, "011111111", "000000000",
                 "0111111111", "0000000000", "0000000000",
                 "0000000010", "1111111111", "1111111110",
                 99, 0, 0);
        // Upstream stops after a stuff bit: underrun, idle, stuff count retained.
        run_test(4, "1111100", "1111111",
                 "111110011", "000001000", "000000010",
                 "000000000", "111110111", "111111100",
                 6, 0, 1);
        // Abort together with bit_tick in STUFF, then the remaining bits form a new frame.
        run_test(5, "11111000", "11111111",
                 "1111110001", "0000000000", "0000000000",
                 "0000000010", "1111101111", "1111101110",
                 99, 6, 0);
        // Reset mid-frame, between clk edges, right after a stuff bit.
        run_test(6, "1111100", "1111111",
                 "111110", "000001", "000000",
                 "000000", "111110", "111111",
                 99, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_bit",      {31'd0, tx_bit},      32'd1);
        chk("midrst_busy",        {31'd0, busy},        32'd0);
        chk("midrst_stuff_count", {24'd0, stuff_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("frame_done_after_rst", {31'd0, frame_done}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        run_mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
